// File: rtl/sync_line_detector.sv
// Line timing recovery: measures sync/back/display/front lengths from a sync + data-enable
// pair, regenerates the pixel coordinate and flags lock once consecutive lines repeat.
module sync_line_detector #(
    parameter int CNT_W      = 11,
    parameter int LOCK_LINES = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync_in,
    input  logic             i_de_in,
    output logic             o_de_out,
    output logic [CNT_W-1:0] o_coord,
    output logic             o_eol,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_sync_len,
    output logic [CNT_W-1:0] o_back_len,
    output logic [CNT_W-1:0] o_disp_len,
    output logic [CNT_W-1:0] o_front_len
);

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_BACK  = 3'd2;
    localparam logic [2:0] ST_DISP  = 3'd3;
    localparam logic [2:0] ST_FRONT = 3'd4;

    localparam int               MW         = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [MW-1:0]    MATCH_ZERO = {MW{1'b0}};
    localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
    localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_LINES);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_s;
    logic [CNT_W-1:0] r_b;
    logic [CNT_W-1:0] r_d;
    logic             r_sa_q;
    logic             r_de_out;
    logic [CNT_W-1:0] r_coord;
    logic             r_eol;
    logic             r_err;
    logic             r_locked;
    logic [MW-1:0]    r_match;
    logic             r_valid;
    logic [CNT_W-1:0] r_sync_len;
    logic [CNT_W-1:0] r_back_len;
    logic [CNT_W-1:0] r_disp_len;
    logic [CNT_W-1:0] r_front_len;

    logic             w_sa;
    logic             w_rise;
    logic [2:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_x_nx;
    logic [CNT_W-1:0] w_s_nx;
    logic [CNT_W-1:0] w_b_nx;
    logic [CNT_W-1:0] w_d_nx;
    logic             w_pix;
    logic [CNT_W-1:0] w_coord_nx;
    logic             w_close;
    logic             w_err;
    logic             w_same;
    logic [MW-1:0]    w_match_nx;

    assign w_sa   = SYNC_POL ? i_sync_in : ~i_sync_in;
    assign w_rise = w_sa & ~r_sa_q;
    // The closing tuple's front length is the running count at the sync rise.
    assign w_same = r_valid &
                    ({r_s, r_b, r_d, r_cnt} == {r_sync_len, r_back_len, r_disp_len, r_front_len});

    // Phase tracking: next state, counters, pixel emission and violation detection.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_x_nx     = r_x;
        w_s_nx     = r_s;
        w_b_nx     = r_b;
        w_d_nx     = r_d;
        w_pix      = 1'b0;
        w_coord_nx = CNT_ZERO;
        w_close    = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_rise) begin
                    w_state_nx = ST_SYNC;
                    w_cnt_nx   = CNT_ONE;
                end else begin
                    w_cnt_nx   = CNT_ZERO;
                end
            end
            ST_SYNC: begin
                if (w_sa) begin
                    if (r_cnt == CNT_MAX) begin
                        w_err = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_ONE;
                    end
                end else if (i_de_in) begin
                    // The first active pixel is the one that ends the porch.
                    w_s_nx     = r_cnt;
                    w_b_nx     = CNT_ZERO;
                    w_state_nx = ST_DISP;
                    w_pix      = 1'b1;
                    w_x_nx     = CNT_ONE;
                end else begin
                    w_s_nx     = r_cnt;
                    w_state_nx = ST_BACK;
                    w_cnt_nx   = CNT_ONE;
                end
            end
            ST_BACK: begin
                if (w_rise) begin
                    w_err = 1'b1;
                end else if (i_de_in) begin
                    w_b_nx     = r_cnt;
                    w_state_nx = ST_DISP;
                    w_pix      = 1'b1;
                    w_x_nx     = CNT_ONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_err = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            ST_DISP: begin
                if (i_de_in) begin
                    if (w_rise || (r_x == CNT_MAX)) begin
                        w_err = 1'b1;
                    end else begin
                        w_pix      = 1'b1;
                        w_coord_nx = r_x;
                        w_x_nx     = r_x + CNT_ONE;
                    end
                end else begin
                    w_d_nx     = r_x;
                    w_state_nx = ST_FRONT;
                    w_cnt_nx   = CNT_ONE;
                end
            end
            ST_FRONT: begin
                if (i_de_in) begin
                    w_err = 1'b1;
                end else if (w_rise) begin
                    w_close    = 1'b1;
                    w_state_nx = ST_SYNC;
                    w_cnt_nx   = CNT_ONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_err = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_HUNT;
                w_cnt_nx   = CNT_ZERO;
            end
        endcase
        if (w_err) begin
            w_state_nx = ST_HUNT;
            w_cnt_nx   = CNT_ZERO;
            w_pix      = 1'b0;
            w_coord_nx = CNT_ZERO;
        end else begin
            w_x_nx = w_x_nx;
        end
    end

    // Consecutive-match counter, saturating at the lock threshold.
    always_comb begin
        if (w_same) begin
            if (r_match == MATCH_FULL) begin
                w_match_nx = MATCH_FULL;
            end else begin
                w_match_nx = r_match + MATCH_ONE;
            end
        end else begin
            w_match_nx = MATCH_ONE;
        end
    end

    // State and output registers; disabled clocks hold state and clear the pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_HUNT;
            r_cnt       <= CNT_ZERO;
            r_x         <= CNT_ZERO;
            r_s         <= CNT_ZERO;
            r_b         <= CNT_ZERO;
            r_d         <= CNT_ZERO;
            r_sa_q      <= 1'b0;
            r_de_out    <= 1'b0;
            r_coord     <= CNT_ZERO;
            r_eol       <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_match     <= MATCH_ZERO;
            r_valid     <= 1'b0;
            r_sync_len  <= CNT_ZERO;
            r_back_len  <= CNT_ZERO;
            r_disp_len  <= CNT_ZERO;
            r_front_len <= CNT_ZERO;
        end else if (i_en) begin
            r_sa_q   <= w_sa;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_x      <= w_x_nx;
            r_s      <= w_s_nx;
            r_b      <= w_b_nx;
            r_d      <= w_d_nx;
            r_de_out <= w_pix;
            r_coord  <= w_coord_nx;
            r_eol    <= w_close;
            r_err    <= w_err;
            if (w_err) begin
                r_locked <= 1'b0;
                r_match  <= MATCH_ZERO;
                r_valid  <= 1'b0;
            end else if (w_close) begin
                r_sync_len  <= r_s;
                r_back_len  <= r_b;
                r_disp_len  <= r_d;
                r_front_len <= r_cnt;
                r_match     <= w_match_nx;
                r_valid     <= 1'b1;
                r_locked    <= (w_match_nx == MATCH_FULL);
            end
        end else begin
            r_eol <= 1'b0;
            r_err <= 1'b0;
        end
    end

    assign o_de_out    = r_de_out;
    assign o_coord     = r_coord;
    assign o_eol       = r_eol;
    assign o_locked    = r_locked;
    assign o_err       = r_err;
    assign o_sync_len  = r_sync_len;
    assign o_back_len  = r_back_len;
    assign o_disp_len  = r_disp_len;
    assign o_front_len = r_front_len;

endmodule

// File: tb/tb_sync_line_detector.sv
// Bench for sync_line_detector: drives whole lines from (sync, back, display, front) tuples
// and predicts eol/lens/locked/coord from the line history kept in a queue.
module tb_sync_line_detector;

    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sync_in;
    logic          de_in;
    logic          de_out;
    logic          eol;
    logic          locked;
    logic          err;
    logic [CW-1:0] coord;
    logic [CW-1:0] sync_len;
    logic [CW-1:0] back_len;
    logic [CW-1:0] disp_len;
    logic [CW-1:0] front_len;

    typedef struct {
        int s;
        int b;
        int d;
        int f;
    } tup_t;

    int            total = 0;
    int            bad = 0;
    tup_t          hist[$];
    tup_t          cur;
    tup_t          prev;
    bit            open_line;
    int            en_mode;
    int            coords[$];
    logic          s_eol;
    logic          s_err;
    logic          s_locked;
    logic          s_de;
    logic [CW-1:0] s_coord;
    logic [4*CW-1:0] s_lens;
    int            rs, rb, rd, rf;
    int            err_at, err_n;

    always #5 clk = ~clk;

    sync_line_detector #(.CNT_W(CW), .LOCK_LINES(2), .SYNC_POL(1'b0)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sync_in   (sync_in),
        .i_de_in     (de_in),
        .o_de_out    (de_out),
        .o_coord     (coord),
        .o_eol       (eol),
        .o_locked    (locked),
        .o_err       (err),
        .o_sync_len  (sync_len),
        .o_back_len  (back_len),
        .o_disp_len  (disp_len),
        .o_front_len (front_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit same_tup(input tup_t a, input tup_t b);
        return (a.s == b.s) && (a.b == b.b) && (a.d == b.d) && (a.f == b.f);
    endfunction

    // Locked when the two most recent closed lines since the last hunt are identical.
    function automatic bit model_locked();
        int n;
        n = hist.size();
        if (n < 2) return 1'b0;
        return same_tup(hist[n-1], hist[n-2]);
    endfunction

    function automatic logic [4*CW-1:0] lens_of(input tup_t t);
        return {CW'(t.s), CW'(t.b), CW'(t.d), CW'(t.f)};
    endfunction

    // One clock: drive (sa is the active-level sync), sample #1 after the edge.
    task automatic tick(input logic e, input logic sa, input logic de);
        en      = e;
        sync_in = ~sa;
        de_in   = de;
        @(posedge clk);
        #1;
        if (e) begin
            s_eol    = eol;
            s_err    = err;
            s_locked = locked;
            s_de     = de_out;
            s_coord  = coord;
            s_lens   = {sync_len, back_len, disp_len, front_len};
            if (de_out) coords.push_back(int'(coord));
        end else if (!rst) begin
            chk("quiet_when_en_low", {62'd0, eol, err}, 64'd0);
        end
    endtask

    task automatic en_cycle(input logic sa, input logic de);
        int idle;
        idle = (en_mode == 1) ? 1 : ((en_mode == 2) ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < idle; i++) tick(1'b0, sa, de);
        tick(1'b1, sa, de);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) en_cycle(1'b0, 1'b0);
    endtask

    task automatic check_close();
        if (open_line) begin
            hist.push_back(cur);
            chk("eol", {63'd0, s_eol}, 64'd1);
            chk("lens", {20'd0, s_lens}, {20'd0, lens_of(cur)});
            chk("locked", {63'd0, s_locked}, {63'd0, model_locked()});
        end else begin
            chk("no_eol_first_line", {63'd0, s_eol}, 64'd0);
        end
        chk("no_err", {63'd0, s_err}, 64'd0);
    endtask

    task automatic check_coords(input int d);
        int bad_at;
        bad_at = 0;
        for (int k = 0; k < coords.size(); k++) begin
            if (bad_at == 0 && coords[k] != k) bad_at = k + 1;
        end
        chk("coord_count", coords.size(), d);
        chk("coord_seq_bad_at", bad_at, 0);
    endtask

    task automatic drive_line(input int s, input int b, input int d, input int f);
        coords.delete();
        for (int i = 0; i < s; i++) begin
            en_cycle(1'b1, 1'b0);
            if (i == 0) check_close();
        end
        for (int i = 0; i < b; i++) en_cycle(1'b0, 1'b0);
        for (int i = 0; i < d; i++) en_cycle(1'b0, 1'b1);
        for (int i = 0; i < f; i++) en_cycle(1'b0, 1'b0);
        check_coords(d);
        open_line = 1'b1;
        cur = '{s, b, d, f};
    endtask

    task automatic forget_history();
        hist.delete();
        open_line = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync_in = 1'b1; de_in = 1'b0;
        en_mode = 0; open_line = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        chk("reset_outputs", {5'd0, de_out, eol, locked, err, coord, sync_len, back_len,
                              disp_len, front_len}, 64'd0);
        rst = 1'b0;
        idle_cycles(4);

        // Nominal timing with en held high, then with en toggling.
        repeat (3) drive_line(192, 96, 1280, 32);
        en_mode = 1;
        repeat (2) drive_line(192, 96, 1280, 32);

        // Display shortened by one pixel.
        en_mode = 0;
        repeat (3) drive_line(192, 96, 1279, 32);

        // Sync rises in the middle of the display.
        coords.delete();
        for (int i = 0; i < 192; i++) begin
            en_cycle(1'b1, 1'b0);
            if (i == 0) check_close();
        end
        prev = cur;
        for (int i = 0; i < 96; i++) en_cycle(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) en_cycle(1'b0, 1'b1);
        en_cycle(1'b1, 1'b1);
        chk("disp_sync_err", {63'd0, s_err}, 64'd1);
        chk("disp_sync_locked", {63'd0, s_locked}, 64'd0);
        chk("disp_sync_de_coord", {52'd0, s_de, s_coord}, 64'd0);
        chk("disp_sync_lens_kept", {20'd0, s_lens}, {20'd0, lens_of(prev)});
        forget_history();
        repeat (5) en_cycle(1'b1, 1'b0);
        idle_cycles(6);
        repeat (4) drive_line(40, 20, 200, 10);

        // Sync held far past the counter range.
        prev = cur;
        err_at = -1;
        err_n = 0;
        for (int i = 0; i < 2100; i++) begin
            en_cycle(1'b1, 1'b0);
            if (i == 0) begin
                check_close();
            end else if (s_err) begin
                err_n++;
                if (err_at < 0) err_at = i;
            end
        end
        chk("sat_err_index", err_at, 2047);
        chk("sat_err_pulses", err_n, 1);
        chk("sat_lens_kept", {20'd0, s_lens}, {20'd0, lens_of(prev)});
        chk("sat_locked", {63'd0, s_locked}, 64'd0);
        forget_history();
        idle_cycles(5);

        // Reset in the middle of the display.
        drive_line(20, 10, 64, 8);
        for (int i = 0; i < 20; i++) begin
            en_cycle(1'b1, 1'b0);
            if (i == 0) check_close();
        end
        for (int i = 0; i < 10; i++) en_cycle(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) en_cycle(1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b1);
        chk("midline_reset_outputs", {5'd0, de_out, eol, locked, err, coord, sync_len,
                                      back_len, disp_len, front_len}, 64'd0);
        rst = 1'b0;
        forget_history();
        idle_cycles(5);
        repeat (3) drive_line(20, 10, 64, 8);

        // Random tuples, often repeated, with a random enable duty cycle.
        en_mode = 2;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || $urandom_range(0, 1) == 0) begin
                rs = int'($urandom_range(1, 12));
                rb = int'($urandom_range(1, 12));
                rd = int'($urandom_range(1, 40));
                rf = int'($urandom_range(1, 12));
            end
            drive_line(rs, rb, rd, rf);
        end
        drive_line(4, 4, 4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
